// File: rtl/binary_to_grey_counter.sv
// Up/down binary counter with registered binary and Grey-coded outputs plus a wrap pulse.
// Optional registered Grey parity output enabled by defining GREY_PARITY_EN.
module binary_to_grey_counter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_bin,
  output logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] grey,
  output logic             wrap
`ifdef GREY_PARITY_EN
  ,
  output logic             grey_par
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] bin_d,  bin_q;
  logic [WIDTH-1:0] grey_d, grey_q;
  logic             wrap_d, wrap_q;

  always_comb begin
    bin_d  = bin_q;
    wrap_d = 1'b0;
    if (load) begin
      bin_d = load_bin;
    end else if (en) begin
      if (up) begin
        bin_d  = bin_q + ONE;
        wrap_d = &bin_q;
      end else begin
        bin_d  = bin_q - ONE;
        wrap_d = ~|bin_q;
      end
    end
    // Grey derived from the next binary value so both registers update together.
    grey_d = bin_d ^ (bin_d >> 1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bin_q  <= '0;
      grey_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      grey_q <= grey_d;
      wrap_q <= wrap_d;
    end
  end

  assign bin  = bin_q;
  assign grey = grey_q;
  assign wrap = wrap_q;

`ifdef GREY_PARITY_EN
  logic par_d, par_q;

  assign par_d = ^grey_d;

  always_ff @(posedge clk) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end

  assign grey_par = par_q;
`endif

endmodule

// File: tb/tb_binary_to_grey_counter.sv
// Self-checking bench for binary_to_grey_counter (WIDTH=4): directed table, hand sequences, random vs model.
module tb_binary_to_grey_counter;

  logic       clk = 1'b0;
  logic       rst_n, en, up, load;
  logic [3:0] load_bin;
  logic [3:0] bin, grey;
  logic       wrap;
`ifdef GREY_PARITY_EN
  logic       grey_par;
`endif

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_bin  = 0;
  int m_wrap = 0;

  always #5 clk = ~clk;

  binary_to_grey_counter #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_bin (load_bin),
    .bin      (bin),
    .grey     (grey),
    .wrap     (wrap)
`ifdef GREY_PARITY_EN
    ,
    .grey_par (grey_par)
`endif
  );

  typedef struct {
    logic       rst_n, en, up, load;
    logic [3:0] load_bin;
    logic [3:0] exp_bin, exp_grey;
    logic       exp_wrap;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int grey_of(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  function automatic int parity4(input int v);
    return (v ^ (v >> 1) ^ (v >> 2) ^ (v >> 3)) & 1;
  endfunction

  // Drive inputs, take one edge, sample #1 later and advance the model.
  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic [3:0] lb);
    rst_n = r; en = e; up = u; load = l; load_bin = lb;
    @(posedge clk);
    #1;
    if (!r) begin
      m_bin = 0; m_wrap = 0;
    end else if (l) begin
      m_bin = lb; m_wrap = 0;
    end else if (e) begin
      m_wrap = ((u && m_bin == 15) || (!u && m_bin == 0)) ? 1 : 0;
      m_bin  = (m_bin + (u ? 1 : 15)) % 16;
    end else begin
      m_wrap = 0;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_bin"},  int'(bin),  m_bin);
    check({tag, "_grey"}, int'(grey), grey_of(m_bin));
    check({tag, "_wrap"}, int'(wrap), m_wrap);
`ifdef GREY_PARITY_EN
    check({tag, "_par"},  int'(grey_par), parity4(grey_of(m_bin)));
`endif
  endtask

  initial begin
    logic [3:0] up_seq[16];
    logic [3:0] prev_g;
    logic       prev_p;
    int         r;
    logic       rr, re, ru, rl;
    logic [3:0] rlb;

    up_seq = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100, 4'b1100,
               4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};

    //           rst en up ld  lbin     bin      grey     wrap
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1110, 4'b1001, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'b0101, 4'b0101, 4'b0111, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 4'b1011, 4'b1011, 4'b1110, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1100, 4'b1010, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'b0111, 4'b0111, 4'b0100, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0111, 4'b0100, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b1111, 4'b0111, 4'b0100, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'b0000, 4'b0111, 4'b0100, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 4'b1100, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0111, 4'b0100, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 4'b1000, 4'b1100, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0111, 4'b0100, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b1, 4'b1010, 4'b0000, 4'b0000, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111, 4'b1000, 1'b1};

    rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;

    // Reset held for two edges while counting is requested
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
      check("rst_bin",  int'(bin),  0);
      check("rst_grey", int'(grey), 0);
      check("rst_wrap", int'(wrap), 0);
`ifdef GREY_PARITY_EN
      check("rst_par",  int'(grey_par), 0);
`endif
    end

    // Full up-count lap
    prev_g = grey;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
      check("up_bin",  int'(bin),  (i + 1) % 16);
      check("up_grey", int'(grey), int'(up_seq[i]));
      check("up_wrap", int'(wrap), (i == 15) ? 1 : 0);
      check("up_onebit", $countones(grey ^ prev_g), 1);
      prev_g = grey;
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    check("post_wrap", int'(wrap), 0);
    check("post_bin",  int'(bin),  1);

    // Directed table
    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst_n, vecs[i].en, vecs[i].up, vecs[i].load, vecs[i].load_bin);
      check($sformatf("vec%0d_bin", i),  int'(bin),  int'(vecs[i].exp_bin));
      check($sformatf("vec%0d_grey", i), int'(grey), int'(vecs[i].exp_grey));
      check($sformatf("vec%0d_wrap", i), int'(wrap), int'(vecs[i].exp_wrap));
    end

    // Reset mid-count at bin=0110 then resume counting
    step(1'b1, 1'b0, 1'b0, 1'b1, 4'b0000);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    check("mid_bin",  int'(bin),  6);
    check("mid_grey", int'(grey), 5);
`ifdef GREY_PARITY_EN
    check("mid_par",  int'(grey_par), 0);
`endif
    step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    check("midrst_bin",  int'(bin),  0);
    check("midrst_grey", int'(grey), 0);
`ifdef GREY_PARITY_EN
    check("midrst_par",  int'(grey_par), 0);
    prev_p = grey_par;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, (i % 2 == 0), 1'b0, 4'b0000);
      check("par_toggle", int'(grey_par), int'(~prev_p));
      prev_p = grey_par;
    end
`else
    prev_p = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    check("midrst_step", int'(bin), 1);
`endif

    // Randomised traffic against the model
    prev_g = grey;
    for (int i = 0; i < 400; i++) begin
      r   = $urandom_range(0, 99);
      rr  = (r >= 4);
      rl  = ($urandom_range(0, 7) == 0);
      re  = ($urandom_range(0, 3) != 0);
      ru  = 1'($urandom);
      rlb = 4'($urandom);
      step(rr, re, ru, rl, rlb);
      check_model("rnd");
      if (rr && !rl && re) check("rnd_onebit", $countones(grey ^ prev_g), 1);
      prev_g = grey;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/binary_to_grey_counter.md
Name: binary_to_grey_counter

Overview:
- Registered up/down binary counter that presents its count in both binary and Grey (reflected binary) code.
- Grey output changes by exactly one bit per count step. This makes it the source end for Grey-coded values consumed by the existing Grey-to-binary converter, e.g. pointer or position buses that cross to other logic.
- Includes a synchronous load for presetting the count and a one-cycle wrap pulse at the modulus boundary.

Parameters:
- WIDTH, 4, bit width of the counter and of both the binary and Grey outputs (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- en  input  1  count enable; one step per clock while high.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when counting.
- load  input  1  synchronous load strobe.
- load_bin  input  WIDTH  binary value to load when load=1.
- bin  output  WIDTH  registered binary count.
- grey  output  WIDTH  registered Grey code of bin.
- wrap  output  1  one-cycle pulse marking a modulus wrap.

Behaviour:
- All outputs are registered on the rising edge of clk. There is no combinational path from inputs to outputs.
- Reset: when rst_n=0 at a clock edge, bin=0, grey=0 and wrap=0. Reset has priority over load and en, and takes effect on the next edge even mid-count. rst_n is not used asynchronously.
- Priority (rst_n=1), evaluated per edge:
  - load=1: bin <= load_bin; wrap <= 0. en and up are ignored.
  - load=0, en=1, up=1: bin <= bin+1, modulo 2^WIDTH.
  - load=0, en=1, up=0: bin <= bin-1, modulo 2^WIDTH.
  - load=0, en=0: hold bin; wrap <= 0.
- Grey encoding: grey is always the Grey code of bin, i.e. bit i = bin[i] XOR bin[i+1] and the MSB = bin[WIDTH-1].
  - grey is computed from next-state bin and registered in the same edge, so bin and grey are never skewed; both have latency 1 cycle from the controlling inputs.
  - Carry/borrow width: the next-bin computation is exactly WIDTH bits and the carry out is discarded.
- Wrap:
  - wrap=1 for exactly the one cycle following an edge where en=1, load=0, and either up=1 with bin = all-ones (becomes 0) or up=0 with bin = 0 (becomes all-ones).
  - Otherwise wrap=0.
  - Continuous counting produces a single-cycle wrap pulse every 2^WIDTH cycles.
- Single-bit-step guarantee: for every count step, including both wrap transitions, grey differs from its previous value in exactly one bit. A load may change any number of bits.
- Direction change: up may toggle on any cycle. The next step uses the new direction with no dead cycle.
- Load during en: load wins; no step occurs on that edge, and counting resumes from load_bin on the following enabled edge.

Optional Feature:
- Macro: GREY_PARITY_EN.
- Defined: adds output port grey_par (1 bit, registered), equal to the XOR of all grey bits for the next state. Reset value is 0.
  - On every count step it toggles.
  - On a load it takes the parity of the Grey code of load_bin.
  - It is held when en=0.
  - Downstream logic uses it to detect a missed or duplicated step.
- Not defined: port grey_par and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset (WIDTH=4): hold rst_n=0 for 2 edges with en=1, up=1 -> bin=0000, grey=0000, wrap=0 after each edge. Release -> first step gives bin=0001, grey=0001.
- Up count: en=1, up=1 for 16 edges from 0 -> grey sequence 0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000,0000.
  - Exactly one grey bit changes per step.
  - wrap=1 only in the cycle after the 1000->0000 transition (bin 1111->0000).
- Down wrap: load_bin=0000 with load=1, then en=1, up=0 -> bin=1111, grey=1000, wrap=1 for one cycle. Next edge gives bin=1110, grey=1001, wrap=0.
- Load priority: bin=0101, load=1, load_bin=1011, en=1, up=1 -> bin=1011, grey=1110, wrap=0. Next enabled edge gives bin=1100, grey=1010.
- Hold and direction change: en=0 for 3 edges at bin=0111 -> bin and grey unchanged (grey=0100). Then en=1 alternating up=1/up=0 -> bin toggles 1000/0111, grey toggles 1100/0100.
- Reset mid-count with GREY_PARITY_EN defined: count to bin=0110 (grey=0101, grey_par=0), then rst_n=0 for one edge -> bin=0, grey=0, grey_par=0. grey_par then toggles on each subsequent step.
